// File: rtl/ventana_pkg.sv
// ventana_pkg: shared types and helpers for the 3x3 window generator.
// Rev 1.0
`default_nettype none

package ventana_pkg;

  localparam int PIX_W_DEF   = 8;
  localparam int SLOT_CENTRE = 4;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_e;

  // Window slot for neighbour (k, l), k = row offset + 1, l = column offset + 1.
  function automatic int slot_idx(input int k, input int l);
    return 3 * k + l;
  endfunction

  function automatic int clamp_idx(input int idx, input int lim);
    if (idx < 0) return 0;
    else if (idx > lim - 1) return lim - 1;
    else return idx;
  endfunction

  function automatic logic [1:0] mod3_inc(input logic [1:0] s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/generador_ventana_3x3_buffer_lineas.sv
// buffer_lineas: three image rows in registers, one write port, nine clamped read ports.
// Rev 1.0
`default_nettype none

module buffer_lineas
  import ventana_pkg::*;
#(
  parameter int WIDTH  = 100,
  parameter int HEIGHT = 100,
  parameter int PIX_W  = PIX_W_DEF,
  localparam int CW    = $clog2(WIDTH),
  localparam int RW    = $clog2(HEIGHT)
) (
  input  logic               clk,
  input  logic               wr_en_i,
  input  logic [1:0]         wr_slot_i,
  input  logic [CW-1:0]      wr_col_i,
  input  logic [PIX_W-1:0]   wr_data_i,
  input  logic [RW-1:0]      rd_row_i,
  input  logic [1:0]         rd_slot_i,
  input  logic [CW-1:0]      rd_col_i,
  output logic [9*PIX_W-1:0] window_o
);

  logic [PIX_W-1:0] mem_q [3][WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_slot_i][wr_col_i] <= wr_data_i;
  end

  // Row offset after clamping is -1, 0 or +1; it shifts the centre row's slot modulo 3.
  generate
    for (genvar k = 0; k < 3; k++) begin : g_row
      logic [1:0] slot;
      assign slot = 2'((int'(rd_slot_i) + 3 + clamp_idx(int'(rd_row_i) + k - 1, HEIGHT)
                        - int'(rd_row_i)) % 3);
      for (genvar l = 0; l < 3; l++) begin : g_col
        logic [CW-1:0] col;
        assign col = CW'(clamp_idx(int'(rd_col_i) + l - 1, WIDTH));
        assign window_o[slot_idx(k, l)*PIX_W +: PIX_W] = mem_q[slot][col];
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/generador_ventana_3x3.sv
// generador_ventana_3x3: streaming 3x3 edge-replicated window generator with valid/ready on both sides.
// Rev 1.0
`default_nettype none

module generador_ventana_3x3
  import ventana_pkg::*;
#(
  parameter int WIDTH  = 100,
  parameter int HEIGHT = 100,
  parameter int PIX_W  = PIX_W_DEF,
  localparam int CW    = $clog2(WIDTH),
  localparam int RW    = $clog2(HEIGHT),
  localparam int NW    = $clog2(WIDTH*HEIGHT+1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PIX_W-1:0]   in_pixel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [9*PIX_W-1:0] out_window,
  output logic [RW-1:0]      out_row,
  output logic [CW-1:0]      out_col
);

  state_e             state_q, state_d;
  logic [NW-1:0]      in_cnt_q;
  logic [RW-1:0]      in_row_q, nr_q, out_row_q;
  logic [CW-1:0]      in_col_q, nc_q, out_col_q;
  logic [1:0]         wr_slot_q, rd_slot_q;
  logic               out_valid_q;
  logic [9*PIX_W-1:0] out_window_q;
  logic [9*PIX_W-1:0] window;

  logic accept, take, last_in, last_held, frame_done, avail, load;
  int   need;

  assign in_ready   = (state_q == RUN) && (int'(in_row_q) != int'(nr_q) + 2);
  assign accept     = in_valid && in_ready;
  assign take       = out_valid_q && out_ready;
  assign last_in    = accept && (int'(in_cnt_q) == WIDTH*HEIGHT - 1);
  assign last_held  = out_valid_q && (out_row_q == RW'(HEIGHT-1)) && (out_col_q == CW'(WIDTH-1));
  assign frame_done = (state_q == DRAIN) && take && last_held;

  // Window (nr, nc) is complete once its bottom-right clamped neighbour has arrived.
  assign need  = clamp_idx(int'(nr_q) + 1, HEIGHT) * WIDTH + clamp_idx(int'(nc_q) + 1, WIDTH);
  assign avail = (state_q == DRAIN) ? !last_held : (int'(in_cnt_q) > need);
  assign load  = avail && (!out_valid_q || out_ready);

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (last_in) state_d = DRAIN;
      DRAIN:   if (frame_done) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  buffer_lineas #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .PIX_W  (PIX_W)
  ) u_buffer (
    .clk       (clk),
    .wr_en_i   (accept),
    .wr_slot_i (wr_slot_q),
    .wr_col_i  (in_col_q),
    .wr_data_i (in_pixel),
    .rd_row_i  (nr_q),
    .rd_slot_i (rd_slot_q),
    .rd_col_i  (nc_q),
    .window_o  (window)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= RUN;
      in_cnt_q     <= '0;
      in_row_q     <= '0;
      in_col_q     <= '0;
      wr_slot_q    <= '0;
      nr_q         <= '0;
      nc_q         <= '0;
      rd_slot_q    <= '0;
      out_valid_q  <= 1'b0;
      out_window_q <= '0;
      out_row_q    <= '0;
      out_col_q    <= '0;
    end else begin
      state_q <= state_d;
      if (frame_done) begin
        in_cnt_q    <= '0;
        in_row_q    <= '0;
        in_col_q    <= '0;
        wr_slot_q   <= '0;
        nr_q        <= '0;
        nc_q        <= '0;
        rd_slot_q   <= '0;
        out_valid_q <= 1'b0;
      end else begin
        if (accept) begin
          in_cnt_q <= in_cnt_q + NW'(1);
          if (in_col_q == CW'(WIDTH-1)) begin
            in_col_q  <= '0;
            in_row_q  <= (in_row_q == RW'(HEIGHT-1)) ? '0 : in_row_q + RW'(1);
            wr_slot_q <= mod3_inc(wr_slot_q);
          end else begin
            in_col_q <= in_col_q + CW'(1);
          end
        end
        if (load) begin
          out_valid_q  <= 1'b1;
          out_window_q <= window;
          out_row_q    <= nr_q;
          out_col_q    <= nc_q;
          if (nc_q == CW'(WIDTH-1)) begin
            nc_q      <= '0;
            nr_q      <= (nr_q == RW'(HEIGHT-1)) ? '0 : nr_q + RW'(1);
            rd_slot_q <= mod3_inc(rd_slot_q);
          end else begin
            nc_q <= nc_q + CW'(1);
          end
        end else if (take) begin
          out_valid_q <= 1'b0;
        end
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_window = out_window_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;

endmodule

`default_nettype wire
